// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-side bus bundle: AXI-lite AR/R channels to instruction memory plus the
// instruction/next-PC handshake with the downstream stage.
interface ysyx_24100005_ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] dnpc;
    logic        dnpc_valid;

    modport master (
        output araddr, arvalid, rready, inst, inst_pc, inst_err, inst_valid,
        input  arready, rdata, rresp, rvalid, inst_ready, dnpc, dnpc_valid
    );

    modport slave (
        input  araddr, arvalid, rready, inst, inst_pc, inst_err, inst_valid,
        output arready, rdata, rresp, rvalid, inst_ready, dnpc, dnpc_valid
    );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Non-pipelined instruction fetch unit: one AR/R read per instruction, then waits for dnpc.
// Optional performance counters are enabled by defining YSYX_24100005_IFU_PERF_EN.
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24100005_ifu_if.master        bus,
    output logic [31:0]                pc
`ifdef YSYX_24100005_IFU_PERF_EN
    ,
    output logic [63:0]                perf_fetch_cnt,
    output logic [63:0]                perf_stall_cnt
`endif
);
    typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT, S_WPC} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
    logic [1:0]  err_reg, err_next;
    logic [15:0] cnt_reg, cnt_next;
    // Keeps arvalid low for the reset-release cycle so nothing is issued while rst is low.
    logic        live_reg;
    logic        arvalid_c, rready_c, inst_valid_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_REQ;
            pc_reg      <= RESET_PC;
            inst_reg    <= 32'h0;
            inst_pc_reg <= 32'h0;
            err_reg     <= 2'd0;
            cnt_reg     <= 16'h0;
            live_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            live_reg    <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        arvalid_c    = 1'b0;
        rready_c     = 1'b0;
        inst_valid_c = 1'b0;
        case (state_reg)
            S_REQ: begin
                if (live_reg) begin
                    if (pc_reg[1:0] != 2'b00) begin
                        inst_next    = 32'h0;
                        inst_pc_next = pc_reg;
                        err_next     = 2'd3;
                        state_next   = S_OUT;
                    end else begin
                        arvalid_c = 1'b1;
                        if (bus.arready) begin
                            cnt_next   = 16'h0;
                            state_next = S_RESP;
                        end
                    end
                end
            end
            S_RESP: begin
                rready_c = 1'b1;
                // A beat arriving on the very cycle the counter expires still wins.
                if (bus.rvalid) begin
                    inst_next    = bus.rdata;
                    inst_pc_next = pc_reg;
                    err_next     = (bus.rresp != 2'b00) ? 2'd1 : 2'd0;
                    state_next   = S_OUT;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    inst_next    = 32'h0;
                    inst_pc_next = pc_reg;
                    err_next     = 2'd2;
                    state_next   = S_OUT;
                end else begin
                    cnt_next = cnt_reg + 16'h1;
                end
            end
            S_OUT: begin
                inst_valid_c = 1'b1;
                if (bus.inst_ready) begin
                    state_next = S_WPC;
                end
            end
            S_WPC: begin
                if (bus.dnpc_valid) begin
                    pc_next    = bus.dnpc;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    assign bus.araddr     = pc_reg;
    assign bus.arvalid    = arvalid_c;
    assign bus.rready     = rready_c;
    assign bus.inst       = inst_reg;
    assign bus.inst_pc    = inst_pc_reg;
    assign bus.inst_err   = err_reg;
    assign bus.inst_valid = inst_valid_c;
    assign pc             = pc_reg;

`ifdef YSYX_24100005_IFU_PERF_EN
    logic [63:0] fetch_cnt_reg, stall_cnt_reg;
    logic        stall_c;

    assign stall_c = (arvalid_c && !bus.arready) || ((state_reg == S_RESP) && !bus.rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_reg <= 64'h0;
            stall_cnt_reg <= 64'h0;
        end else begin
            if (inst_valid_c && bus.inst_ready) begin
                fetch_cnt_reg <= fetch_cnt_reg + 64'h1;
            end
            if (stall_c) begin
                stall_cnt_reg <= stall_cnt_reg + 64'h1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`endif
endmodule
